// File: rtl/pipeline_adder_tree.sv
// pipeline_adder_tree: pipelined N-operand adder with round/shift/saturate and valid/ready flow control.
// Every stage keeps its own valid bit, so empty stages fill even while the output is stalled.
module pipeline_adder_tree #(
  parameter int NUMBERS_AMOUNT = 9,
  parameter int NUMBER_WIDTH = 16,
  parameter int SIGNED = 0,
  parameter int SHIFT = 0,
  parameter int OUT_WIDTH = 16,
  localparam int SUM_WIDTH = NUMBER_WIDTH + $clog2(NUMBERS_AMOUNT)
) (
  input  logic                                   clk_i,
  input  logic                                   rst_i,
  input  logic                                   data_valid_i,
  output logic                                   data_ready_o,
  input  logic [NUMBERS_AMOUNT*NUMBER_WIDTH-1:0] data_i,
  output logic                                   data_valid_o,
  input  logic                                   data_ready_i,
  output logic [OUT_WIDTH-1:0]                   data_o,
  output logic                                   sat_o
);
  localparam int LEVELS = NUMBERS_AMOUNT > 1 ? $clog2(NUMBERS_AMOUNT) : 1;
  localparam int S = LEVELS + 2;
  localparam int SW = SUM_WIDTH;
  localparam int RW = SW + 1;
  localparam int WW = (OUT_WIDTH > RW ? OUT_WIDTH : RW) + 1;
  localparam bit SG = SIGNED != 0;
  localparam logic signed [RW-1:0] HALF = (RW'(1) << SHIFT) >> 1;
  localparam logic signed [WW-1:0] ONE = WW'(1);
  localparam logic signed [WW-1:0] HI = (ONE <<< (OUT_WIDTH - int'(SG))) - ONE;
  localparam logic signed [WW-1:0] LO = SG ? -(ONE <<< (OUT_WIDTH - 1)) : '0;

  function automatic int cnt(input int l);
    return (NUMBERS_AMOUNT + (1 << l) - 1) >> l;
  endfunction

  // Bit offset of tree level l inside the flat tree vector.
  function automatic int off(input int l);
    int o = 0;
    for (int j = 0; j < l; j++) o += cnt(j) * SW;
    return o;
  endfunction

  localparam int TOT = off(LEVELS + 1);

  logic [S-1:0]         v;
  logic [S-1:0]         ld;
  logic [S-1:0]         vin;
  logic [TOT-1:0]       tree;
  logic [SW-1:0]        sum;
  logic signed [RW-1:0] sx;
  logic signed [RW-1:0] rnd;
  logic signed [RW-1:0] r;
  logic signed [WW-1:0] rw;
  logic                 sat_hi;
  logic                 sat_lo;

  assign vin = {v[S-2:0], data_valid_i};

  // A stage may load when any stage from it onwards has a hole, or the output drains.
  for (genvar k = 0; k < S; k++) begin : g_ld
    assign ld[k] = data_ready_i | ~&v[S-1:k];
  end

  assign data_ready_o = ld[0];
  assign data_valid_o = v[S-1];

  always_ff @(posedge clk_i or posedge rst_i)
    if (rst_i) v <= '0;
    else v <= (ld & vin) | (~ld & v);

  for (genvar i = 0; i < NUMBERS_AMOUNT; i++) begin : g_in
    logic [NUMBER_WIDTH-1:0] op;
    logic [SW-1:0]           q;
    assign op = data_i[i*NUMBER_WIDTH +: NUMBER_WIDTH];
    always_ff @(posedge clk_i)
      if (ld[0] && data_valid_i) q <= SW'($signed({SG && op[NUMBER_WIDTH-1], op}));
    assign tree[i*SW +: SW] = q;
  end

  // An unpaired trailing node passes through by adding zero.
  for (genvar l = 1; l <= LEVELS; l++) begin : g_lvl
    for (genvar i = 0; i < cnt(l); i++) begin : g_node
      localparam int B = off(l - 1) + 2 * i * SW;
      localparam bit PAIR = 2 * i + 1 < cnt(l - 1);
      logic [SW-1:0] q;
      always_ff @(posedge clk_i)
        if (ld[l] && v[l-1]) q <= tree[B +: SW] + (PAIR ? tree[B+SW +: SW] : '0);
      assign tree[off(l)+i*SW +: SW] = q;
    end
  end

  assign sum = tree[off(LEVELS) +: SW];
  assign sx = $signed({SG && sum[SW-1], sum});
  assign rnd = sx + HALF;
  assign r = SG ? (rnd >>> SHIFT) : (rnd >> SHIFT);
  assign rw = WW'(r);
  assign sat_hi = rw > HI;
  assign sat_lo = rw < LO;

  always_ff @(posedge clk_i or posedge rst_i)
    if (rst_i) begin
      data_o <= '0;
      sat_o <= 1'b0;
    end else if (ld[S-1] && v[S-2]) begin
      data_o <= sat_hi ? HI[OUT_WIDTH-1:0] : sat_lo ? LO[OUT_WIDTH-1:0] : rw[OUT_WIDTH-1:0];
      sat_o <= sat_hi || sat_lo;
    end
endmodule

// File: tb/tb_pipeline_adder_tree.sv
// tb_pipeline_adder_tree: scoreboard bench for the pipelined adder tree.
// Main instance: signed N=9 W=8 SHIFT=4 OUT=8; two N=4 W=8 instances exercise saturation.
module tb_pipeline_adder_tree;
  typedef struct {
    int d;
    int s;
    int d2;
    int s2;
    int acc;
    int lat;
  } exp_t;

  logic clk_i = 1'b0;
  logic rst_i = 1'b0;
  always #5 clk_i = ~clk_i;

  logic        m_valid, m_ready_o, m_vout, m_ready, m_sat;
  logic [71:0] m_data;
  logic [7:0]  m_out;
  logic        s_valid, su_ready_o, ss_ready_o, su_vout, ss_vout, su_sat, ss_sat;
  logic [31:0] s_data;
  logic [7:0]  su_out, ss_out;

  pipeline_adder_tree #(.NUMBERS_AMOUNT(9), .NUMBER_WIDTH(8), .SIGNED(1), .SHIFT(4), .OUT_WIDTH(8)) u_dut (
    .clk_i(clk_i), .rst_i(rst_i), .data_valid_i(m_valid), .data_ready_o(m_ready_o), .data_i(m_data),
    .data_valid_o(m_vout), .data_ready_i(m_ready), .data_o(m_out), .sat_o(m_sat));

  pipeline_adder_tree #(.NUMBERS_AMOUNT(4), .NUMBER_WIDTH(8), .SIGNED(0), .SHIFT(0), .OUT_WIDTH(8)) u_sat_u (
    .clk_i(clk_i), .rst_i(rst_i), .data_valid_i(s_valid), .data_ready_o(su_ready_o), .data_i(s_data),
    .data_valid_o(su_vout), .data_ready_i(1'b1), .data_o(su_out), .sat_o(su_sat));

  pipeline_adder_tree #(.NUMBERS_AMOUNT(4), .NUMBER_WIDTH(8), .SIGNED(1), .SHIFT(0), .OUT_WIDTH(8)) u_sat_s (
    .clk_i(clk_i), .rst_i(rst_i), .data_valid_i(s_valid), .data_ready_o(ss_ready_o), .data_i(s_data),
    .data_valid_o(ss_vout), .data_ready_i(1'b1), .data_o(ss_out), .sat_o(ss_sat));

  int   checks = 0;
  int   failures = 0;
  int   cyc = 0;
  int   lat_on = 0;
  bit   bp_on = 0;
  bit   p_stall = 0;
  logic [7:0] p_d;
  logic p_s;
  exp_t mq[$];
  exp_t sq[$];

  always @(posedge clk_i) cyc <= cyc + 1;

  task automatic check(input string tag, input logic signed [31:0] got, input logic signed [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d at cycle %0d", tag, got, exp, cyc);
    end
  endtask

  function automatic exp_t model_m(input logic [71:0] w, input int a, input int l);
    exp_t e;
    int s = 0;
    int r;
    for (int k = 0; k < 9; k++) s += int'($signed(w[k*8 +: 8]));
    r = (s + 8) >>> 4;
    e.d = r > 127 ? 127 : r < -128 ? -128 : r;
    e.s = int'(r > 127 || r < -128);
    e.d2 = 0;
    e.s2 = 0;
    e.acc = a;
    e.lat = l;
    return e;
  endfunction

  function automatic exp_t model_s(input logic [31:0] w, input int a);
    exp_t e;
    int u = 0;
    int s = 0;
    for (int k = 0; k < 4; k++) begin
      u += int'(w[k*8 +: 8]);
      s += int'($signed(w[k*8 +: 8]));
    end
    e.d = u > 255 ? 255 : u;
    e.s = int'(u > 255);
    e.d2 = s > 127 ? 127 : s < -128 ? -128 : s;
    e.s2 = int'(s > 127 || s < -128);
    e.acc = a;
    e.lat = 1;
    return e;
  endfunction

  always @(negedge clk_i) begin
    exp_t e;
    if (rst_i) p_stall = 0;
    else begin
      if (m_valid && m_ready_o) mq.push_back(model_m(m_data, cyc, lat_on));
      if (s_valid && su_ready_o) sq.push_back(model_s(s_data, cyc));
      if (p_stall) begin
        check("hold_valid", m_vout, 1);
        check("hold_data", $signed(m_out), $signed(p_d));
        check("hold_sat", m_sat, p_s);
      end
      p_stall = m_vout && !m_ready;
      p_d = m_out;
      p_s = m_sat;
      if (m_vout && m_ready) begin
        check("main_q_nonempty", int'(mq.size() > 0), 1);
        if (mq.size() > 0) begin
          e = mq.pop_front();
          check("main_data", $signed(m_out), e.d);
          check("main_sat", m_sat, e.s);
          if (e.lat != 0) check("main_latency", cyc - e.acc, 6);
        end
      end
      if (su_vout) begin
        check("sat_q_nonempty", int'(sq.size() > 0), 1);
        if (sq.size() > 0) begin
          e = sq.pop_front();
          check("usat_data", su_out, e.d);
          check("usat_sat", su_sat, e.s);
          check("ssat_valid", ss_vout, 1);
          check("ssat_data", $signed(ss_out), e.d2);
          check("ssat_sat", ss_sat, e.s2);
          check("sat_latency", cyc - e.acc, 4);
        end
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk_i);
      #1;
    end
  endtask

  task automatic send(input logic [71:0] w);
    bit ok = 0;
    m_valid = 1;
    m_data = w;
    for (int n = 0; n < 200 && !ok; n++) begin
      @(negedge clk_i);
      ok = m_ready_o;
      @(posedge clk_i);
      #1;
    end
    m_valid = 0;
    if (!ok) check("send_timeout", ok, 1);
  endtask

  task automatic send_s(input logic [31:0] w);
    s_valid = 1;
    s_data = w;
    tick(1);
    s_valid = 0;
  endtask

  task automatic drain();
    for (int n = 0; n < 300 && (mq.size() > 0 || sq.size() > 0); n++) tick(1);
    tick(10);
    check("drain_main", mq.size(), 0);
    check("drain_sat", sq.size(), 0);
  endtask

  function automatic logic [71:0] rnd72();
    return {$urandom, $urandom, 8'($urandom)};
  endfunction

  initial begin
    int acc;
    m_valid = 0; m_data = '0; m_ready = 1; s_valid = 0; s_data = '0;
    #1 rst_i = 1;
    #1;
    check("rst_valid", m_vout, 0);
    check("rst_data", m_out, 0);
    check("rst_sat", m_sat, 0);
    tick(3);
    rst_i = 0;
    check("rst_ready", m_ready_o, 1);

    lat_on = 1;
    send({9{8'h80}});
    send({9{8'h7f}});
    send(72'd8);
    send({64'd0, 8'hf8});
    send(72'd24);
    send({64'd0, 8'he8});
    for (int i = 0; i < 4; i++) send(rnd72());
    drain();

    lat_on = 0;
    bp_on = 1;
    fork
      while (bp_on) begin
        @(posedge clk_i);
        #1 m_ready = 1'($urandom_range(0, 1));
      end
    join_none
    for (int i = 0; i < 20; i++) begin
      tick($urandom_range(0, 2));
      send(rnd72());
    end
    bp_on = 0;
    @(posedge clk_i);
    #2 m_ready = 1;
    drain();

    m_ready = 0;
    m_valid = 1;
    acc = 0;
    for (int n = 0; n < 15; n++) begin
      m_data = rnd72();
      @(negedge clk_i);
      if (m_ready_o) acc++;
      @(posedge clk_i);
      #1;
    end
    m_valid = 0;
    check("full_accepts", acc, 6);
    check("full_ready", m_ready_o, 0);
    m_ready = 1;
    drain();

    m_ready = 0;
    send(rnd72());
    tick(3);
    send(rnd72());
    tick(8);
    check("bubble_ready", m_ready_o, 1);
    m_ready = 1;
    @(negedge clk_i);
    check("bubble_a", m_vout, 1);
    @(negedge clk_i);
    check("bubble_b", m_vout, 1);
    @(negedge clk_i);
    check("bubble_end", m_vout, 0);
    drain();

    m_ready = 0;
    for (int i = 0; i < 4; i++) send(rnd72());
    tick(4);
    check("prerst_valid", m_vout, 1);
    #2 rst_i = 1;
    #1;
    check("midrst_valid", m_vout, 0);
    check("midrst_data", m_out, 0);
    mq.delete();
    tick(1);
    rst_i = 0;
    m_ready = 1;
    lat_on = 1;
    check("postrst_ready", m_ready_o, 1);
    for (int i = 0; i < 3; i++) send(rnd72());
    drain();

    send_s({8'd0, 8'd100, 8'd100, 8'd100});
    send_s({4{8'h80}});
    send_s({8'd40, 8'd30, 8'd20, 8'd10});
    send_s({4{8'hff}});
    send_s({8'd0, 8'd0, 8'd1, 8'd127});
    send_s({8'd0, 8'd27, 8'd50, 8'd50});
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired checks=%0d failures=%0d", checks, failures);
    $fatal(1);
  end
endmodule
